// File: rtl/nvdla_csc_op_group_ctrl_if.sv
// Bundle between the CSC op-group controller and its neighbours: the
// single-register file (producer in; consumer/status out), the dual-register
// decode (op-enable write pulse) and the CSC datapath (op_start / dp_done).
//
// Handshake semantics: there is no valid/ready pair on this bundle. op_en_wr,
// dp_done, op_start and each done_intr bit are single-cycle pulses that are
// acted on in the cycle they are high; the receiver never back-pressures.
// consumer, status_*, op_en_* and op_group are level signals straight from
// flops (status through a small decode), stable for a whole cycle.
interface nvdla_csc_op_group_ctrl_if;
  logic       producer;
  logic       op_en_wr;
  logic       op_en_wr_data;
  logic       dp_done;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       op_en_0;
  logic       op_en_1;
  logic       op_start;
  logic       op_group;
  logic [1:0] done_intr;
  logic       dbg_busy;
  logic [3:0] dbg_gap_cnt;

  modport master (
    output producer, op_en_wr, op_en_wr_data, dp_done,
    input  consumer, status_0, status_1, op_en_0, op_en_1,
    input  op_start, op_group, done_intr, dbg_busy, dbg_gap_cnt
  );

  modport slave (
    input  producer, op_en_wr, op_en_wr_data, dp_done,
    output consumer, status_0, status_1, op_en_0, op_en_1,
    output op_start, op_group, done_intr, dbg_busy, dbg_gap_cnt
  );
endinterface

// File: rtl/nvdla_csc_op_group_ctrl.sv
// CSC ping-pong op-group controller. Tracks the op-enable bit of each register
// group and the consumer pointer, and launches datapath ops strictly in
// alternating group order starting from group 0. A programmable idle gap
// separates each completion from the next launch.
module nvdla_csc_op_group_ctrl #(
  parameter int unsigned START_GAP = 1
) (
  input logic                        nvdla_core_clk,
  input logic                        nvdla_core_rstn,
  nvdla_csc_op_group_ctrl_if.slave   ctrl_if
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [3:0] GAP_LD  = 4'(START_GAP);

  localparam logic [1:0] STS_IDLE    = 2'd0;
  localparam logic [1:0] STS_RUNNING = 2'd1;
  localparam logic [1:0] STS_PENDING = 2'd2;

  logic [1:0] op_en_q,     op_en_d;
  logic       consumer_q,  consumer_d;
  logic [0:0] state_q,     state_d;
  logic [3:0] gap_cnt_q,   gap_cnt_d;
  logic       op_start_q,  op_start_d;
  logic [1:0] done_intr_q, done_intr_d;

  logic busy;
  logic start_cond;
  logic complete;
  logic wr_blocked;

  assign busy       = (state_q == ST_BUSY);
  assign start_cond = !busy && op_en_q[consumer_q] && (gap_cnt_q == 4'd0);
  assign complete   = busy && ctrl_if.dp_done;
  // A clear of the in-flight group is dropped; once its completion lands in
  // the same cycle the group is no longer in flight, so the clear applies.
  assign wr_blocked = (ctrl_if.producer == consumer_q) && busy && !complete;

  function automatic logic [1:0] grp_status(input logic en, input logic running);
    if (!en)         return STS_IDLE;
    else if (running) return STS_RUNNING;
    else              return STS_PENDING;
  endfunction

  // Next-state: gap countdown, launch, completion, then the op-enable write
  // last so a same-cycle write overrides the completion's clear.
  always_comb begin
    op_en_d     = op_en_q;
    consumer_d  = consumer_q;
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    op_start_d  = 1'b0;
    done_intr_d = 2'b00;

    if (gap_cnt_q != 4'd0) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end

    if (start_cond) begin
      op_start_d = 1'b1;
      state_d    = ST_BUSY;
    end

    if (complete) begin
      state_d                 = ST_IDLE;
      op_en_d[consumer_q]     = 1'b0;
      done_intr_d[consumer_q] = 1'b1;
      consumer_d              = ~consumer_q;
      gap_cnt_d               = GAP_LD;
    end

    if (ctrl_if.op_en_wr) begin
      if (ctrl_if.op_en_wr_data) begin
        op_en_d[ctrl_if.producer] = 1'b1;
      end else if (!wr_blocked) begin
        op_en_d[ctrl_if.producer] = 1'b0;
      end
    end
  end

  // State flops, cleared immediately on reset assertion.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_q     <= 2'b00;
      consumer_q  <= 1'b0;
      state_q     <= ST_IDLE;
      gap_cnt_q   <= 4'd0;
      op_start_q  <= 1'b0;
      done_intr_q <= 2'b00;
    end else begin
      op_en_q     <= op_en_d;
      consumer_q  <= consumer_d;
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      op_start_q  <= op_start_d;
      done_intr_q <= done_intr_d;
    end
  end

  assign ctrl_if.consumer    = consumer_q;
  assign ctrl_if.op_en_0     = op_en_q[0];
  assign ctrl_if.op_en_1     = op_en_q[1];
  assign ctrl_if.status_0    = grp_status(op_en_q[0], busy && (consumer_q == 1'b0));
  assign ctrl_if.status_1    = grp_status(op_en_q[1], busy && (consumer_q == 1'b1));
  assign ctrl_if.op_start    = op_start_q;
  assign ctrl_if.op_group    = consumer_q;
  assign ctrl_if.done_intr   = done_intr_q;
  assign ctrl_if.dbg_busy    = busy;
  assign ctrl_if.dbg_gap_cnt = gap_cnt_q;

endmodule

// File: tb/tb_nvdla_csc_op_group_ctrl.sv
// Directed bench for the CSC op-group controller. Two instances share the
// same stimulus: one with a 3-cycle start gap (main checks) and one with no
// gap (back-to-back launch timing).
module tb_nvdla_csc_op_group_ctrl;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nvdla_csc_op_group_ctrl_if a_if ();
  nvdla_csc_op_group_ctrl_if b_if ();

  assign b_if.producer      = a_if.producer;
  assign b_if.op_en_wr      = a_if.op_en_wr;
  assign b_if.op_en_wr_data = a_if.op_en_wr_data;
  assign b_if.dp_done       = a_if.dp_done;

  nvdla_csc_op_group_ctrl #(.START_GAP(3)) u_dut_gap3 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .ctrl_if         (a_if.slave)
  );

  nvdla_csc_op_group_ctrl #(.START_GAP(0)) u_dut_gap0 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .ctrl_if         (b_if.slave)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch-order monitor for the gap-3 instance.
  always @(negedge clk) begin
    if (rstn && a_if.op_start) got_q.push_back({31'd0, a_if.op_group});
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic wr_op_en(input logic g, input logic d);
    a_if.producer      = g;
    a_if.op_en_wr      = 1'b1;
    a_if.op_en_wr_data = d;
    step();
    a_if.op_en_wr      = 1'b0;
    a_if.op_en_wr_data = 1'b0;
  endtask

  task automatic pulse_done();
    a_if.dp_done = 1'b1;
    step();
    a_if.dp_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!a_if.op_start && k < 20) begin
      step();
      k++;
    end
    check_eq({tag, "_start"}, {31'd0, a_if.op_start}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    a_if.producer      = 1'b0;
    a_if.op_en_wr      = 1'b0;
    a_if.op_en_wr_data = 1'b0;
    a_if.dp_done       = 1'b0;

    // Reset values, then a single group-0 op.
    do_reset();
    check_eq("rst_consumer", {31'd0, a_if.consumer}, 32'd0);
    check_eq("rst_status_0", {30'd0, a_if.status_0}, 32'd0);
    check_eq("rst_status_1", {30'd0, a_if.status_1}, 32'd0);
    check_eq("rst_op_en",    {30'd0, a_if.op_en_1, a_if.op_en_0}, 32'd0);
    check_eq("rst_op_start", {31'd0, a_if.op_start}, 32'd0);
    check_eq("rst_done_intr", {30'd0, a_if.done_intr}, 32'd0);
    check_eq("rst_b_consumer", {31'd0, b_if.consumer}, 32'd0);

    wr_op_en(1'b0, 1'b1);
    check_eq("s1_op_en0",    {31'd0, a_if.op_en_0}, 32'd1);
    check_eq("s1_stat0_pend", {30'd0, a_if.status_0}, 32'd2);
    check_eq("s1_no_start",  {31'd0, a_if.op_start}, 32'd0);
    step();
    check_eq("s1_start",     {31'd0, a_if.op_start}, 32'd1);
    check_eq("s1_group",     {31'd0, a_if.op_group}, 32'd0);
    check_eq("s1_stat0_run", {30'd0, a_if.status_0}, 32'd1);
    check_eq("s1_busy",      {31'd0, a_if.dbg_busy}, 32'd1);
    check_eq("s1_b_start",   {31'd0, b_if.op_start}, 32'd1);
    exp_q.push_back(32'd0);
    step();
    pulse_done();
    check_eq("s1_done_intr", {30'd0, a_if.done_intr}, 32'd1);
    check_eq("s1_consumer",  {31'd0, a_if.consumer}, 32'd1);
    check_eq("s1_stat0_idle", {30'd0, a_if.status_0}, 32'd0);
    check_eq("s1_op_en0_clr", {31'd0, a_if.op_en_0}, 32'd0);
    check_eq("s1_gap_load",  {28'd0, a_if.dbg_gap_cnt}, 32'd3);
    step();
    check_eq("s1_intr_clr",  {30'd0, a_if.done_intr}, 32'd0);

    // Both groups enabled: gap 3 vs gap 0 launch timing.
    do_reset();
    wr_op_en(1'b0, 1'b1);
    wr_op_en(1'b1, 1'b1);
    check_eq("s2_start0",    {31'd0, a_if.op_start}, 32'd1);
    check_eq("s2_group0",    {31'd0, a_if.op_group}, 32'd0);
    check_eq("s2_stat1_pend", {30'd0, a_if.status_1}, 32'd2);
    exp_q.push_back(32'd0);
    step();
    pulse_done();
    check_eq("s2_consumer1", {31'd0, a_if.consumer}, 32'd1);
    check_eq("s2_b_consumer1", {31'd0, b_if.consumer}, 32'd1);
    step();
    check_eq("s2_b_start_d2", {31'd0, b_if.op_start}, 32'd1);
    check_eq("s2_b_group1",   {31'd0, b_if.op_group}, 32'd1);
    check_eq("s2_a_quiet_d2", {31'd0, a_if.op_start}, 32'd0);
    for (int i = 3; i <= 4; i++) begin
      step();
      check_eq("s2_a_quiet", {31'd0, a_if.op_start}, 32'd0);
    end
    step();
    check_eq("s2_a_start_d5", {31'd0, a_if.op_start}, 32'd1);
    check_eq("s2_a_group1",   {31'd0, a_if.op_group}, 32'd1);
    check_eq("s2_stat1_run",  {30'd0, a_if.status_1}, 32'd1);
    exp_q.push_back(32'd1);
    step();
    pulse_done();
    check_eq("s2_done_intr1", {30'd0, a_if.done_intr}, 32'd2);
    check_eq("s2_consumer0",  {31'd0, a_if.consumer}, 32'd0);
    check_eq("s2_b_done_intr1", {30'd0, b_if.done_intr}, 32'd2);

    // Group 1 alone waits for group 0.
    do_reset();
    wr_op_en(1'b1, 1'b1);
    bad = 0;
    repeat (50) begin
      if (a_if.status_1 != 2'd2 || a_if.op_start) bad++;
      step();
    end
    check_eq("s3_grp1_held", bad, 32'd0);
    wr_op_en(1'b0, 1'b1);
    step();
    check_eq("s3_start0", {31'd0, a_if.op_start}, 32'd1);
    check_eq("s3_group0", {31'd0, a_if.op_group}, 32'd0);
    exp_q.push_back(32'd0);
    step();
    pulse_done();
    wait_start("s3_g1");
    check_eq("s3_group1",    {31'd0, a_if.op_group}, 32'd1);
    check_eq("s3_stat1_run", {30'd0, a_if.status_1}, 32'd1);
    exp_q.push_back(32'd1);

    // Clearing op-enable: running group ignores, pending group clears.
    wr_op_en(1'b1, 1'b0);
    check_eq("s4_run_keep_stat", {30'd0, a_if.status_1}, 32'd1);
    check_eq("s4_run_keep_en",   {31'd0, a_if.op_en_1}, 32'd1);
    wr_op_en(1'b0, 1'b1);
    check_eq("s4_stat0_pend", {30'd0, a_if.status_0}, 32'd2);
    wr_op_en(1'b0, 1'b0);
    check_eq("s4_stat0_idle", {30'd0, a_if.status_0}, 32'd0);
    check_eq("s4_op_en0_clr", {31'd0, a_if.op_en_0}, 32'd0);
    pulse_done();
    check_eq("s4_done_intr1", {30'd0, a_if.done_intr}, 32'd2);
    check_eq("s4_consumer0",  {31'd0, a_if.consumer}, 32'd0);

    // Re-arm write in the same cycle as the completion.
    wr_op_en(1'b0, 1'b1);
    wait_start("s5_g0");
    check_eq("s5_group0", {31'd0, a_if.op_group}, 32'd0);
    exp_q.push_back(32'd0);
    step();
    a_if.producer      = 1'b0;
    a_if.op_en_wr      = 1'b1;
    a_if.op_en_wr_data = 1'b1;
    a_if.dp_done       = 1'b1;
    step();
    a_if.op_en_wr      = 1'b0;
    a_if.op_en_wr_data = 1'b0;
    a_if.dp_done       = 1'b0;
    check_eq("s5_op_en0",     {31'd0, a_if.op_en_0}, 32'd1);
    check_eq("s5_stat0_pend", {30'd0, a_if.status_0}, 32'd2);
    check_eq("s5_done_intr0", {30'd0, a_if.done_intr}, 32'd1);
    check_eq("s5_consumer1",  {31'd0, a_if.consumer}, 32'd1);

    // Spurious completion while idle.
    step();
    pulse_done();
    check_eq("s6_spur_consumer", {31'd0, a_if.consumer}, 32'd1);
    check_eq("s6_spur_intr",     {30'd0, a_if.done_intr}, 32'd0);
    check_eq("s6_spur_stat0",    {30'd0, a_if.status_0}, 32'd2);
    check_eq("s6_spur_busy",     {31'd0, a_if.dbg_busy}, 32'd0);

    // Asynchronous reset in the middle of an op.
    wr_op_en(1'b1, 1'b1);
    wait_start("s6_g1");
    exp_q.push_back(32'd1);
    step();
    #3;
    rstn = 1'b0;
    #1;
    check_eq("s6_ar_consumer", {31'd0, a_if.consumer}, 32'd0);
    check_eq("s6_ar_status",   {28'd0, a_if.status_1, a_if.status_0}, 32'd0);
    check_eq("s6_ar_op_en",    {30'd0, a_if.op_en_1, a_if.op_en_0}, 32'd0);
    check_eq("s6_ar_busy",     {31'd0, a_if.dbg_busy}, 32'd0);
    check_eq("s6_ar_op_start", {31'd0, a_if.op_start}, 32'd0);
    step();
    rstn = 1'b1;
    pulse_done();
    check_eq("s6_post_done_intr", {30'd0, a_if.done_intr}, 32'd0);
    check_eq("s6_post_consumer",  {31'd0, a_if.consumer}, 32'd0);
    wr_op_en(1'b1, 1'b1);
    step();
    check_eq("s6_g1_no_start", {31'd0, a_if.op_start}, 32'd0);
    check_eq("s6_stat1_pend",  {30'd0, a_if.status_1}, 32'd2);
    wr_op_en(1'b0, 1'b1);
    step();
    check_eq("s6_restart0",    {31'd0, a_if.op_start}, 32'd1);
    check_eq("s6_restart_grp", {31'd0, a_if.op_group}, 32'd0);
    exp_q.push_back(32'd0);
    step();
    step();

    // Launch order seen by the monitor.
    check_eq("order_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("order_%0d", i), got_q[i], exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nvdla_csc_op_group_ctrl.md
# nvdla_csc_op_group_ctrl

Operation controller for the two CSC ping-pong register groups. It tracks each group's op-enable state and the consumer pointer, and launches convolution-sequence ops to the CSC datapath in group order. It produces the `consumer`, `status_0` and `status_1` inputs of the CSC single-register file, and consumes that file's `producer` output together with op-enable writes from the dual-register decode.

## Interface
Parameters:
- START_GAP, default 1: minimum idle cycles between a `dp_done` and the next `op_start`. Legal range is 0..15; a 4-bit gap counter holds it.

Ports (name, direction, width, meaning):
- nvdla_core_clk, input, 1: clock, nvdla_core_clk.
- nvdla_core_rstn, input, 1: reset, asynchronous, active-low.
- producer, input, 1: register group targeted by CSB writes.
- op_en_wr, input, 1: single-cycle pulse, a write to D_OP_ENABLE of group `producer`.
- op_en_wr_data, input, 1: value written (bit 0).
- dp_done, input, 1: single-cycle pulse from the datapath that the current op is finished.
- consumer, output, 1: group currently executing, or next to execute.
- status_0, output, 2: state of group 0 (0 idle, 1 running, 2 pending).
- status_1, output, 2: state of group 1, same encoding.
- op_en_0, output, 1: op-enable flop for group 0.
- op_en_1, output, 1: op-enable flop for group 1.
- op_start, output, 1: single-cycle pulse that launches an op on group `op_group`.
- op_group, output, 1: group of the op launched or in flight; equals `consumer` while `busy`.
- done_intr, output, 2: bit g pulses for one cycle when group g's op completes.

## Operation
State flops: `op_en[1:0]`, `consumer`, `busy`, `gap_cnt[3:0]`, `op_start`, `done_intr[1:0]`.
- Reset value of all of them is 0, so outputs reset to: consumer 0, status 0/0, op_en 0/0, op_start 0, done_intr 0.

Start condition: `start_cond = !busy && op_en[consumer] && gap_cnt==0`.
- On the next edge: op_start is set to 1 for one cycle, busy is set to 1, op_group is set to consumer.

Completion: `dp_done` while busy causes, on the next edge:
- busy cleared;
- op_en[consumer] cleared;
- done_intr[consumer] pulses;
- consumer toggles;
- gap_cnt loaded with START_GAP.
- `dp_done` while !busy is ignored, with no state change.

Gap counter: gap_cnt decrements by 1 each cycle while it is non-zero. It saturates at 0 and does not wrap.

Op-enable write to group g = producer:
- data 1: op_en[g] is set. Writing 1 to an already-set op_en is a no-op.
- data 0: op_en[g] is cleared, unless g==consumer && busy, in which case the write is ignored (an in-flight op cannot be cancelled).
- Write and `dp_done` in the same cycle on g==consumer: the completion is applied first, then the write. Data 1 therefore re-arms the group (op_en ends 1, status pending). Data 0 gives op_en 0.

Status of group g, combinational from flops:
- 0 (idle) when !op_en[g];
- 1 (running) when op_en[g] && busy && consumer==g;
- 2 (pending) otherwise.
- Status value 3 is never produced.

Ordering: groups always execute alternately, starting from group 0 after reset. If group 1 is enabled while group 0 is idle, it stays pending until group 0 is enabled and has completed.

## Timing
- op_en_wr at cycle t: op_en and status update at t+1.
- If the start condition then holds, op_start is high in cycle t+2 and status shows running in t+2.
- dp_done at cycle d: done_intr and the consumer toggle are visible in d+1, and gap_cnt==START_GAP in d+1.
- Next op_start (if the other group is enabled) is in cycle d+2+START_GAP.
- START_GAP=0 gives back-to-back operation: op_start in d+2.
- op_start can never assert while busy, and cannot assert in two consecutive cycles.
- Asynchronous reset mid-op: all flops clear immediately and consumer returns to 0. An outstanding dp_done after reset is ignored.

## Test plan
- Reset, then write producer=0, data=1 at t. Required: op_en_0=1 and status_0=2 at t+1; op_start=1, op_group=0, status_0=1 at t+2; dp_done at d gives done_intr=2'b01, consumer=1, status_0=0 at d+1.
- Enable both groups, START_GAP=3. Required: group-0 op_start; dp_done at d; group-1 op_start exactly at d+5. With START_GAP=0, exactly at d+2.
- Enable group 1 only. Required: status_1 stays 2 and no op_start for 50 cycles. Then enable group 0: op 0 runs first, then op 1.
- Write data 0 to the running group. Required: ignored, status stays 1. Write data 0 to the pending group: op_en clears and status goes to 0.
- Write data 1 to group 0 in the same cycle as its dp_done. Required: op_en_0=1, status_0=2, done_intr[0] pulses, consumer=1.
- Spurious dp_done while idle: no change. Assert reset while busy: all outputs 0 asynchronously, and operation restarts from group 0.
